// File: rtl/xlr8_sim_mailbox_pkg.sv
// Shared constants for the host-to-CPU mailbox: default I/O addresses,
// status/control bit positions and the FIFO depth legality check.
package xlr8_sim_mailbox_pkg;

  localparam logic [5:0] MBX_DATA_ADR = 6'h1A;
  localparam logic [5:0] MBX_STAT_ADR = 6'h1B;
  localparam logic [5:0] MBX_CTRL_ADR = 6'h1C;

  localparam int unsigned STAT_NE   = 7;
  localparam int unsigned STAT_FULL = 6;
  localparam int unsigned STAT_UNF  = 5;

  localparam int unsigned CTRL_IE    = 0;
  localparam int unsigned CTRL_FLUSH = 1;

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/xlr8_sim_mailbox_if.sv
// I/O register bus and host byte port of the mailbox.
interface xlr8_sim_mailbox_if;

  logic [5:0] adr;
  logic [7:0] dbus_in;
  logic       iore;
  logic       iowe;
  logic [7:0] dbus_out;
  logic       io_out_en;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic       irq;

  modport master (
    output adr, dbus_in, iore, iowe, host_valid, host_data,
    input  dbus_out, io_out_en, host_ready, irq
  );

  modport slave (
    input  adr, dbus_in, iore, iowe, host_valid, host_data,
    output dbus_out, io_out_en, host_ready, irq
  );

endinterface

// File: rtl/xlr8_mbx_fifo.sv
// Byte FIFO with synchronous flush; push/pop are ignored when full/empty.
module xlr8_mbx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       wdata,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xlr8_sim_mailbox.sv
// Host-to-CPU byte mailbox on the AVR I/O register bus: MBXD pops the FIFO,
// MBXS reports status with a sticky underflow flag, MBXC holds irq enable/flush.
module xlr8_sim_mailbox
  import xlr8_sim_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter logic [5:0]  DATA_ADR = MBX_DATA_ADR,
  parameter logic [5:0]  STAT_ADR = MBX_STAT_ADR,
  parameter logic [5:0]  CTRL_ADR = MBX_CTRL_ADR
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clken,
  xlr8_sim_mailbox_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  if (!depth_ok(DEPTH) || DATA_ADR == STAT_ADR || DATA_ADR == CTRL_ADR ||
      STAT_ADR == CTRL_ADR) begin : g_param_check
    $error("xlr8_sim_mailbox: illegal DEPTH or overlapping register addresses");
  end

  logic             hit_data, hit_stat, hit_ctrl;
  logic             rd_data, rd_stat, rd_ctrl;
  logic             flush_req, unf_clr, unf_set;
  logic             push, pop;
  logic             unf, rx_ie;
  logic [7:0]       head;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [4:0]       cnt5;
  logic [7:0]       stat, ctrl;
  logic             unused_dbus;

  // rstn gates decode so the read path is silent throughout reset
  assign hit_data = rstn & clken & (bus.adr == DATA_ADR);
  assign hit_stat = rstn & clken & (bus.adr == STAT_ADR);
  assign hit_ctrl = rstn & clken & (bus.adr == CTRL_ADR);

  assign rd_data = bus.iore & hit_data;
  assign rd_stat = bus.iore & hit_stat;
  assign rd_ctrl = bus.iore & hit_ctrl;

  assign flush_req = bus.iowe & hit_ctrl & bus.dbus_in[CTRL_FLUSH];
  assign unf_clr   = bus.iowe & hit_stat & bus.dbus_in[STAT_UNF];
  assign unf_set   = rd_data & empty;
  assign pop       = rd_data & ~empty;

  assign bus.host_ready = rstn & clken & ~full & ~flush_req;
  assign push           = bus.host_valid & bus.host_ready;

  assign bus.io_out_en = rd_data | rd_stat | rd_ctrl;
  assign bus.irq       = rx_ie & ~empty;
  assign unused_dbus   = ^{bus.dbus_in[7:6], bus.dbus_in[4:2]};

  xlr8_mbx_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush_req),
    .wdata (bus.host_data),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      unf   <= 1'b0;
      rx_ie <= 1'b0;
    end else begin
      if (unf_set)      unf <= 1'b1;
      else if (unf_clr) unf <= 1'b0;
      if (bus.iowe & hit_ctrl) rx_ie <= bus.dbus_in[CTRL_IE];
    end
  end

  always_comb begin
    cnt5             = '0;
    cnt5[CNT_W-1:0]  = count;
    stat             = '0;
    stat[STAT_NE]    = ~empty;
    stat[STAT_FULL]  = full;
    stat[STAT_UNF]   = unf;
    stat[4:0]        = cnt5;
    ctrl             = '0;
    ctrl[CTRL_IE]    = rx_ie;
  end

  always_comb begin
    bus.dbus_out = '0;
    if (rd_data)      bus.dbus_out = empty ? 8'h00 : head;
    else if (rd_stat) bus.dbus_out = stat;
    else if (rd_ctrl) bus.dbus_out = ctrl;
  end

endmodule
